// File: rtl/csi_rx_raw10_unpack.sv
// ---------------------------------------------------------------------------
// csi_rx_raw10_unpack
// Unpacks a CSI-2 RAW10 long-packet payload (two bytes per cycle) into groups
// of four 10-bit pixels, and keeps per-line pixel and per-frame line counts.
//
// Ports
//   clock            single clock for all logic
//   reset_n          asynchronous active-low reset
//   enable           high = run, low = freeze all state (strobes forced low)
//   payload_in       [7:0] earlier byte, [15:8] later byte
//   payload_valid    payload_in valid while a long packet is received
//   in_frame         high between frame start and frame end
//   pixel_out        P0=[9:0] P1=[19:10] P2=[29:20] P3=[39:30], held between strobes
//   pixel_valid      one-cycle strobe, pixel_out updated
//   line_end         one-cycle strobe after the payload ends
//   line_err         with line_end when the byte count was not a multiple of 5
//   pixels_per_line  pixel count of the last completed line (saturating)
//   frame_lines      lines completed in the current frame (saturating)
// ---------------------------------------------------------------------------
module csi_rx_raw10_unpack #(
    parameter int PIX_CNT_W  = 14,
    parameter int LINE_CNT_W = 12
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic [15:0]           payload_in,
    input  logic                  payload_valid,
    input  logic                  in_frame,
    output logic [39:0]           pixel_out,
    output logic                  pixel_valid,
    output logic                  line_end,
    output logic                  line_err,
    output logic [PIX_CNT_W-1:0]  pixels_per_line,
    output logic [LINE_CNT_W-1:0] frame_lines
);

    // Byte accumulator: byte k lives at [8k+7:8k]; bytes at or above r_bc
    // are always zero so new bytes can be OR-ed in at position r_bc.
    logic [39:0]           r_acc;
    logic [2:0]            r_bc;
    logic                  r_in_line;
    logic                  r_in_frame_d;
    logic [39:0]           r_pix_out;
    logic                  r_pix_valid;
    logic                  r_line_end;
    logic                  r_line_err;
    logic [PIX_CNT_W-1:0]  r_pix_cnt;
    logic [PIX_CNT_W-1:0]  r_ppl;
    logic [LINE_CNT_W-1:0] r_frame_lines;

    logic                  w_v;
    logic                  w_eol;
    logic                  w_frame_rise;
    logic [55:0]           w_ext;
    logic [3:0]            w_bc_sum;
    logic [3:0]            w_bc_left;
    logic                  w_group;
    logic [39:0]           w_pix;
    logic [PIX_CNT_W:0]    w_pix_sum;
    logic [PIX_CNT_W-1:0]  w_pix_next;

    assign w_v          = payload_valid & enable;
    // A frozen (enable=0) cycle is never an end of line.
    assign w_eol        = enable & ~payload_valid & r_in_line;
    assign w_frame_rise = enable & in_frame & ~r_in_frame_d;

    assign w_ext     = {16'd0, r_acc} | ({40'd0, payload_in} << {r_bc, 3'b000});
    assign w_bc_sum  = {1'b0, r_bc} + 4'd2;
    assign w_bc_left = w_bc_sum - 4'd5;
    assign w_group   = w_v & (w_bc_sum >= 4'd5);

    // Pn[9:2] = Bn, Pn[1:0] = B4[2n+1:2n]
    always_comb begin
        w_pix = '0;
        for (int n = 0; n < 4; n++) begin
            w_pix[n*10 +: 10] = {w_ext[n*8 +: 8], w_ext[32 + 2*n +: 2]};
        end
    end

    assign w_pix_sum  = {1'b0, r_pix_cnt} + (PIX_CNT_W+1)'(4);
    assign w_pix_next = w_pix_sum[PIX_CNT_W] ? {PIX_CNT_W{1'b1}} : w_pix_sum[PIX_CNT_W-1:0];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_acc         <= '0;
            r_bc          <= '0;
            r_in_line     <= 1'b0;
            r_in_frame_d  <= 1'b0;
            r_pix_out     <= '0;
            r_pix_valid   <= 1'b0;
            r_line_end    <= 1'b0;
            r_line_err    <= 1'b0;
            r_pix_cnt     <= '0;
            r_ppl         <= '0;
            r_frame_lines <= '0;
        end else if (enable) begin
            r_in_frame_d <= in_frame;
            r_pix_valid  <= w_group;
            r_line_end   <= w_eol;
            r_line_err   <= w_eol & (r_bc != 3'd0);

            if (w_group) begin
                r_pix_out <= w_pix;
            end

            if (w_eol) begin
                // Leftover bytes of a short/odd line are dropped here.
                r_acc     <= '0;
                r_bc      <= '0;
                r_in_line <= 1'b0;
                r_ppl     <= r_pix_cnt;
                r_pix_cnt <= '0;
            end else if (w_v) begin
                r_in_line <= 1'b1;
                if (w_group) begin
                    r_acc     <= {32'd0, w_ext[47:40]};
                    r_bc      <= w_bc_left[2:0];
                    r_pix_cnt <= w_pix_next;
                end else begin
                    r_acc <= w_ext[39:0];
                    r_bc  <= w_bc_sum[2:0];
                end
            end

            // Frame start wins over a coincident end of line.
            if (w_frame_rise) begin
                r_frame_lines <= '0;
            end else if (w_eol && in_frame && !(&r_frame_lines)) begin
                r_frame_lines <= r_frame_lines + 1'b1;
            end
        end
    end

    // Strobes are held while frozen but masked, so each appears for exactly
    // one enabled cycle.
    assign pixel_out       = r_pix_out;
    assign pixel_valid     = r_pix_valid & enable;
    assign line_end        = r_line_end & enable;
    assign line_err        = r_line_err & enable;
    assign pixels_per_line = r_ppl;
    assign frame_lines     = r_frame_lines;

endmodule

// File: tb/tb_csi_rx_raw10_unpack.sv
module tb_csi_rx_raw10_unpack;

    logic        clock;
    logic        reset_n;
    logic        enable;
    logic [15:0] payload_in;
    logic        payload_valid;
    logic        in_frame;
    logic [39:0] pixel_out;
    logic        pixel_valid;
    logic        line_end;
    logic        line_err;
    logic [13:0] pixels_per_line;
    logic [11:0] frame_lines;

    csi_rx_raw10_unpack #(.PIX_CNT_W(14), .LINE_CNT_W(12)) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .enable          (enable),
        .payload_in      (payload_in),
        .payload_valid   (payload_valid),
        .in_frame        (in_frame),
        .pixel_out       (pixel_out),
        .pixel_valid     (pixel_valid),
        .line_end        (line_end),
        .line_err        (line_err),
        .pixels_per_line (pixels_per_line),
        .frame_lines     (frame_lines)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        int         nwords;
        logic [7:0] base;
        int         exp_groups;
        logic       exp_err;
        int         exp_ppl;
    } line_vec_t;

    typedef struct {
        logic err;
        int   ppl;
    } line_exp_t;

    int checks   = 0;
    int failures = 0;

    logic [7:0]  bq[$];
    logic [39:0] exp_pix[$];
    line_exp_t   exp_line[$];
    int          m_pix = 0;
    bit          m_in_line = 1'b0;

    int   strobes   = 0;
    int   line_ends = 0;
    logic last_err  = 1'b0;
    int   last_ppl  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [39:0] unpack(input logic [39:0] bytes);
        logic [39:0] r;
        r = '0;
        for (int n = 0; n < 4; n++) begin
            r[n*10 +: 10] = {bytes[n*8 +: 8], bytes[32 + 2*n +: 2]};
        end
        return r;
    endfunction

    function automatic logic [15:0] mkword(input logic [7:0] base, input int k);
        logic [7:0] lo;
        logic [7:0] hi;
        lo = base ^ 8'((2*k)*29 + 3);
        hi = base ^ 8'((2*k+1)*29 + 3);
        return {hi, lo};
    endfunction

    task automatic send_word(input logic [15:0] w);
        logic [39:0] g;
        @(negedge clock);
        enable        = 1'b1;
        payload_valid = 1'b1;
        payload_in    = w;
        bq.push_back(w[7:0]);
        bq.push_back(w[15:8]);
        m_in_line = 1'b1;
        while (bq.size() >= 5) begin
            for (int i = 0; i < 5; i++) g[i*8 +: 8] = bq.pop_front();
            exp_pix.push_back(unpack(g));
            m_pix += 4;
        end
    endtask

    task automatic idle(input int n, input logic fr);
        line_exp_t e;
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            enable        = 1'b1;
            payload_valid = 1'b0;
            payload_in    = 16'hDEAD;
            in_frame      = fr;
            if (m_in_line) begin
                e.err = (bq.size() != 0);
                e.ppl = m_pix;
                exp_line.push_back(e);
                bq.delete();
                m_pix     = 0;
                m_in_line = 1'b0;
            end
        end
    endtask

    task automatic freeze(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            enable        = 1'b0;
            payload_valid = 1'b0;
            payload_in    = 16'hBEEF;
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_pixel_out"}, 64'(pixel_out), 64'd0);
        check({tag, "_pixel_valid"}, 64'(pixel_valid), 64'd0);
        check({tag, "_line_end"}, 64'(line_end), 64'd0);
        check({tag, "_line_err"}, 64'(line_err), 64'd0);
        check({tag, "_ppl"}, 64'(pixels_per_line), 64'd0);
        check({tag, "_frame_lines"}, 64'(frame_lines), 64'd0);
    endtask

    // Scoreboard side: pop expectations as the DUT produces strobes.
    always @(posedge clock) begin
        logic [39:0] ep;
        line_exp_t   el;
        #1;
        if (reset_n) begin
            if (pixel_valid) begin
                strobes++;
                if (exp_pix.size() == 0) begin
                    check("pix_unexpected", 64'(pixel_out), 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    ep = exp_pix.pop_front();
                    check("pixel_out", 64'(pixel_out), 64'(ep));
                end
            end
            if (line_end) begin
                line_ends++;
                last_err = line_err;
                last_ppl = int'(pixels_per_line);
                if (exp_line.size() == 0) begin
                    check("line_end_unexpected", 64'(line_end), 64'd0);
                end else begin
                    el = exp_line.pop_front();
                    check("line_err", 64'(line_err), 64'(el.err));
                    check("pixels_per_line", 64'(pixels_per_line), 64'(el.ppl));
                end
            end else if (line_err) begin
                check("line_err_without_line_end", 64'(line_err), 64'd0);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        line_vec_t tbl[7];
        int        le0;

        tbl[0] = '{5,  8'h10, 2, 1'b0, 8};
        tbl[1] = '{6,  8'h21, 2, 1'b1, 8};
        tbl[2] = '{1,  8'h32, 0, 1'b1, 0};
        tbl[3] = '{2,  8'h43, 0, 1'b1, 0};
        tbl[4] = '{3,  8'h54, 1, 1'b1, 4};
        tbl[5] = '{7,  8'h65, 2, 1'b1, 8};
        tbl[6] = '{10, 8'h76, 4, 1'b0, 16};

        reset_n       = 1'b0;
        enable        = 1'b0;
        payload_valid = 1'b0;
        payload_in    = 16'h0;
        in_frame      = 1'b0;
        #3;
        check_zero_outputs("reset");
        repeat (3) @(negedge clock);
        reset_n = 1'b1;

        // Known-answer group
        strobes = 0;
        send_word(16'h3412);
        send_word(16'h7856);
        send_word(16'hAAE4);
        idle(4, 1'b0);
        check("kat_pixel_out", 64'(pixel_out), 64'({10'h1E3, 10'h15A, 10'h0D1, 10'h048}));
        check("kat_strobes", 64'(strobes), 64'd1);
        check("kat_err", 64'(last_err), 64'd1);
        check("kat_ppl", 64'(last_ppl), 64'd4);
        check("kat_frame_lines", 64'(frame_lines), 64'd0);

        // Table of lines inside one frame
        idle(2, 1'b1);
        for (int i = 0; i < 7; i++) begin
            strobes = 0;
            le0 = line_ends;
            for (int k = 0; k < tbl[i].nwords; k++) send_word(mkword(tbl[i].base, k));
            idle(4, 1'b1);
            check($sformatf("tbl%0d_strobes", i), 64'(strobes), 64'(tbl[i].exp_groups));
            check($sformatf("tbl%0d_line_ends", i), 64'(line_ends), 64'(le0 + 1));
            check($sformatf("tbl%0d_err", i), 64'(last_err), 64'(tbl[i].exp_err));
            check($sformatf("tbl%0d_ppl", i), 64'(last_ppl), 64'(tbl[i].exp_ppl));
            check($sformatf("tbl%0d_frame_lines", i), 64'(frame_lines), 64'(i + 1));
        end

        // in_frame re-rise on the same edge as an end of line
        idle(2, 1'b0);
        for (int k = 0; k < 5; k++) send_word(mkword(8'h88, k));
        idle(1, 1'b1);
        idle(3, 1'b1);
        check("rerise_frame_lines", 64'(frame_lines), 64'd0);
        for (int k = 0; k < 5; k++) send_word(mkword(8'h99, k));
        idle(4, 1'b1);
        check("after_rerise_frame_lines", 64'(frame_lines), 64'd1);

        // enable low mid-line
        strobes = 0;
        le0 = line_ends;
        send_word(mkword(8'hA5, 0));
        send_word(mkword(8'hA5, 1));
        freeze(3);
        check("freeze_no_line_end", 64'(line_ends), 64'(le0));
        for (int k = 2; k < 5; k++) send_word(mkword(8'hA5, k));
        idle(4, 1'b1);
        check("freeze_strobes", 64'(strobes), 64'd2);
        check("freeze_line_ends", 64'(line_ends), 64'(le0 + 1));
        check("freeze_err", 64'(last_err), 64'd0);
        check("freeze_ppl", 64'(last_ppl), 64'd8);

        // reset mid-line
        send_word(mkword(8'h5A, 0));
        send_word(mkword(8'h5A, 1));
        send_word(mkword(8'h5A, 2));
        @(negedge clock);
        reset_n       = 1'b0;
        payload_valid = 1'b0;
        #1;
        check_zero_outputs("midreset");
        bq.delete();
        m_pix     = 0;
        m_in_line = 1'b0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        strobes = 0;
        for (int k = 0; k < 5; k++) send_word(mkword(8'hC3, k));
        idle(4, 1'b1);
        check("postreset_strobes", 64'(strobes), 64'd2);
        check("postreset_err", 64'(last_err), 64'd0);
        check("postreset_ppl", 64'(last_ppl), 64'd8);
        check("postreset_frame_lines", 64'(frame_lines), 64'd1);

        check("pix_queue_empty", 64'(exp_pix.size()), 64'd0);
        check("line_queue_empty", 64'(exp_line.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/csi_rx_raw10_unpack.md
CSI_RX_RAW10_UNPACK -- requirements
Module: csi_rx_raw10_unpack

Interface
REQ-001 SHALL have parameter PIX_CNT_W, default 14, width of per-line pixel counter.
REQ-002 SHALL have parameter LINE_CNT_W, default 12, width of per-frame line counter.
REQ-003 SHALL have port clock  input  1  single clock for all logic.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port enable  input  1  active-high; low freezes all state.
REQ-006 SHALL have port payload_in  input  16 (lane_data_t)  payload word from packet handler; [7:0] = earlier byte, [15:8] = later byte.
REQ-007 SHALL have port payload_valid  input  1  payload_in valid (long packet being received).
REQ-008 SHALL have port in_frame  input  1  high between FS and FE.
REQ-009 SHALL have port pixel_out  output  40  four 10-bit pixels: P0=[9:0], P1=[19:10], P2=[29:20], P3=[39:30].
REQ-010 SHALL have port pixel_valid  output  1  one-cycle strobe, pixel_out valid.
REQ-011 SHALL have port line_end  output  1  one-cycle strobe at end of payload.
REQ-012 SHALL have port line_err  output  1  one-cycle strobe with line_end when payload byte count is not a multiple of 5.
REQ-013 SHALL have port pixels_per_line  output  PIX_CNT_W  pixel count of last completed line.
REQ-014 SHALL have port frame_lines  output  LINE_CNT_W  lines completed in current frame.

Function
REQ-015 SHALL define v = payload_valid & enable; all state updates occur only when enable=1; pixel_valid, line_end, line_err SHALL be 0 when enable=0.
REQ-016 SHALL keep a byte accumulator (40-bit) and byte count bc in 0..5; each cycle with v=1 appends payload_in[7:0] then payload_in[15:8].
REQ-017 SHALL, when bc+2 >= 5, emit one group from the 5 oldest bytes B0..B4 and retain the leftover byte (bc+2-5 = 0 or 1); bc sequence per line SHALL be 0,2,4,1,3,0 (2 groups per 5 words).
REQ-018 SHALL unpack Pn[9:2] = Bn and Pn[1:0] = B4[2n+1:2n] for n = 0..3.
REQ-019 SHALL register pixel_out/pixel_valid: pixel_valid high in the cycle after the edge that sampled the completing word; pixel_out holds last value when pixel_valid=0.
REQ-020 SHALL detect end of line at the first edge sampling v=0 after an edge sampling v=1; line_end SHALL be high the following cycle for exactly one cycle.
REQ-021 SHALL, at that edge, set line_err if bc != 0, discard leftover bytes, clear bc to 0.
REQ-022 SHALL count pixels (+4 per group) per line, saturating at 2^PIX_CNT_W-1, load the count into pixels_per_line at the end-of-line edge, and clear the running count.
REQ-023 SHALL clear frame_lines to 0 on the edge sampling a 0->1 transition of in_frame; otherwise increment by 1 at each end-of-line edge while in_frame=1, saturating at 2^LINE_CNT_W-1.
REQ-024 SHALL give clear priority over increment when in_frame rise and end-of-line coincide.
REQ-025 SHALL, for a gap in v with enable=0, not treat the frozen cycles as end of line (end-of-line requires enable=1 and payload_valid=0).
REQ-026 SHALL emit no group and no pixel count for a line whose total bytes < 5; line_end SHALL still pulse.
REQ-027 SHALL have 1-cycle latency with no backpressure; a group completed on the same edge as an end-of-line is impossible (v=0 on that edge).

Reset
REQ-028 SHALL on reset_n=0 asynchronously clear accumulator, bc, counters, pixels_per_line, frame_lines, pixel_out to 0 and all strobes to 0, including mid-line; first valid word after release starts a fresh line at bc=0.

Verification
REQ-029 SHALL verify: words 0x3412, 0x7856, then 0x??E4 -> pixel_valid once with P0=0x048, P1=0x0D1, P2=0x15A, P3=0x1E3.
REQ-030 SHALL verify: 5-word line then v=0 -> 2 pixel_valid strobes, line_end once, line_err=0, pixels_per_line=8.
REQ-031 SHALL verify: 6-word line (12 bytes) -> 2 groups, line_end with line_err=1, pixels_per_line=8, next line starts at bc=0.
REQ-032 SHALL verify: in_frame rise then 3 lines -> frame_lines=3; in_frame re-rise coincident with line end -> frame_lines=0.
REQ-033 SHALL verify: enable low for 3 cycles mid-line -> no line_end, unpacked pixels identical to uninterrupted run.
REQ-034 SHALL verify: reset_n pulsed low after 3 words -> all outputs 0 immediately; following 5-word line yields correct 2 groups.
